// File: rtl/dsp_mac_pkg.sv
// Shared opmode encodings for the DSP multiply-accumulate pipeline.
package dsp_mac_pkg;

  localparam int OPMODE_W = 3;

  typedef enum logic [OPMODE_W-1:0] {
    OP_MUL_ADD = 3'd0,
    OP_PRE_ADD = 3'd1,
    OP_PRE_SUB = 3'd2,
    OP_ACC_ADD = 3'd3,
    OP_ACC_SUB = 3'd4,
    OP_C_ADD   = 3'd5,
    OP_CONCAT  = 3'd6,
    OP_CLR     = 3'd7
  } opmode_e;

endpackage

// File: rtl/dsp_mac_mult.sv
// Second pipeline stage: optional pre-adder on d/a followed by the signed multiplier.
module dsp_mac_mult
  import dsp_mac_pkg::*;
#(
  parameter int IN_DATA_W_1 = 18
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ce,
  input  opmode_e                         opmode,
  input  logic signed [IN_DATA_W_1-1:0]   a,
  input  logic signed [IN_DATA_W_1-1:0]   b,
  input  logic signed [IN_DATA_W_1-1:0]   d,
  output logic signed [2*IN_DATA_W_1:0]   prod_q
);

  localparam int PAW = IN_DATA_W_1 + 1;
  localparam int PRW = 2 * IN_DATA_W_1 + 1;

  logic signed [PAW-1:0] a_ext, d_ext, pre_sum;
  logic signed [PRW-1:0] pre_wide, b_wide, prod_d;

  always_comb begin
    a_ext = {a[IN_DATA_W_1-1], a};
    d_ext = {d[IN_DATA_W_1-1], d};
    case (opmode)
      OP_PRE_ADD: pre_sum = d_ext + a_ext;
      OP_PRE_SUB: pre_sum = d_ext - a_ext;
      default:    pre_sum = a_ext;
    endcase
    // Both factors widened to the product width so the multiply is exact and width-matched.
    pre_wide = {{(PRW-PAW){pre_sum[PAW-1]}}, pre_sum};
    b_wide   = {{(PRW-IN_DATA_W_1){b[IN_DATA_W_1-1]}}, b};
    prod_d   = pre_wide * b_wide;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (ce) begin
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage signed MAC: input registers, pre-add/multiply, post-add into P with sticky overflow.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int IN_DATA_W_1 = 18,
  parameter int IN_DATA_W_2 = 48,
  parameter int OUT_DATA_W  = 48
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ce,
  input  logic                          in_valid,
  input  logic [OPMODE_W-1:0]           opmode,
  input  logic signed [IN_DATA_W_1-1:0] a,
  input  logic signed [IN_DATA_W_1-1:0] b,
  input  logic signed [IN_DATA_W_1-1:0] d,
  input  logic signed [IN_DATA_W_2-1:0] c,
  input  logic                          carryin,
  output logic signed [OUT_DATA_W-1:0]  P,
  output logic                          out_valid,
  output logic                          ovf
);

  localparam int W1  = IN_DATA_W_1;
  localparam int PRW = 2 * W1 + 1;
  localparam int EW  = OUT_DATA_W + 2;

  if (OUT_DATA_W < PRW || OUT_DATA_W < IN_DATA_W_2) begin : g_width_chk
    $error("dsp_mac_pipe: OUT_DATA_W too narrow for product or addend");
  end

  logic                   vld1_q, vld1_d;
  opmode_e                op1_q, op1_d;
  logic signed [W1-1:0]   a1_q, a1_d, b1_q, b1_d, d1_q, d1_d;
  logic signed [IN_DATA_W_2-1:0] c1_q, c1_d;
  logic                   cin1_q, cin1_d;

  logic                   vld2_q, vld2_d;
  opmode_e                op2_q, op2_d;
  logic signed [IN_DATA_W_2-1:0] c2_q, c2_d;
  logic                   cin2_q, cin2_d;
  logic [2*W1-1:0]        cat2_q, cat2_d;
  logic signed [PRW-1:0]  prod2_q;

  logic signed [OUT_DATA_W-1:0] p_q, p_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;

  logic signed [EW-1:0]   x_op, y_op, ci_op, sum;
  logic                   ovf_now;

  always_comb begin
    vld1_d = in_valid;
    op1_d  = opmode_e'(opmode);
    a1_d   = a;
    b1_d   = b;
    d1_d   = d;
    c1_d   = c;
    cin1_d = carryin;

    vld2_d = vld1_q;
    op2_d  = op1_q;
    c2_d   = c1_q;
    cin2_d = cin1_q;
    cat2_d = {a1_q, b1_q};
  end

  dsp_mac_mult #(.IN_DATA_W_1(W1)) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .opmode (op1_q),
    .a      (a1_q),
    .b      (b1_q),
    .d      (d1_q),
    .prod_q (prod2_q)
  );

  // Post-add is done two bits wider than P so overflow falls out of the spare sign bits.
  always_comb begin
    x_op  = '0;
    y_op  = '0;
    ci_op = {{(EW-1){1'b0}}, cin2_q};
    case (op2_q)
      OP_MUL_ADD, OP_PRE_ADD: begin
        x_op = {{(EW-PRW){prod2_q[PRW-1]}}, prod2_q};
        y_op = {{(EW-IN_DATA_W_2){c2_q[IN_DATA_W_2-1]}}, c2_q};
      end
      OP_PRE_SUB: x_op = {{(EW-PRW){prod2_q[PRW-1]}}, prod2_q};
      OP_ACC_ADD: begin
        x_op = {{2{p_q[OUT_DATA_W-1]}}, p_q};
        y_op = {{(EW-PRW){prod2_q[PRW-1]}}, prod2_q};
      end
      OP_ACC_SUB: begin
        x_op  = {{2{p_q[OUT_DATA_W-1]}}, p_q};
        y_op  = -{{(EW-PRW){prod2_q[PRW-1]}}, prod2_q};
        ci_op = -{{(EW-1){1'b0}}, cin2_q};
      end
      OP_C_ADD: x_op = {{(EW-IN_DATA_W_2){c2_q[IN_DATA_W_2-1]}}, c2_q};
      OP_CONCAT: begin
        x_op  = {{(EW-2*W1){1'b0}}, cat2_q};
        y_op  = {{(EW-IN_DATA_W_2){c2_q[IN_DATA_W_2-1]}}, c2_q};
        ci_op = '0;
      end
      default: ci_op = '0;
    endcase
    sum     = x_op + y_op + ci_op;
    ovf_now = (sum[EW-1:OUT_DATA_W-1] != '0) && (sum[EW-1:OUT_DATA_W-1] != '1);

    p_d         = p_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (vld2_q) begin
      out_valid_d = 1'b1;
      if (op2_q == OP_CLR) begin
        p_d   = '0;
        ovf_d = 1'b0;
      end else begin
        p_d   = sum[OUT_DATA_W-1:0];
        ovf_d = ovf_q | ovf_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q      <= 1'b0;
      op1_q       <= OP_MUL_ADD;
      a1_q        <= '0;
      b1_q        <= '0;
      d1_q        <= '0;
      c1_q        <= '0;
      cin1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      op2_q       <= OP_MUL_ADD;
      c2_q        <= '0;
      cin2_q      <= 1'b0;
      cat2_q      <= '0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      vld1_q      <= vld1_d;
      op1_q       <= op1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      d1_q        <= d1_d;
      c1_q        <= c1_d;
      cin1_q      <= cin1_d;
      vld2_q      <= vld2_d;
      op2_q       <= op2_d;
      c2_q        <= c2_d;
      cin2_q      <= cin2_d;
      cat2_q      <= cat2_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign P         = p_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe with hand-computed expected results.
module tb_dsp_mac_pipe;

  logic               clk;
  logic               rst_n;
  logic               ce;
  logic               in_valid;
  logic [2:0]         opmode;
  logic signed [17:0] a, b, d;
  logic signed [47:0] c;
  logic               carryin;
  logic signed [47:0] P;
  logic               out_valid;
  logic               ovf;

  int checks   = 0;
  int failures = 0;

  dsp_mac_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .opmode    (opmode),
    .a         (a),
    .b         (b),
    .d         (d),
    .c         (c),
    .carryin   (carryin),
    .P         (P),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic signed [17:0] aa,
                       input logic signed [17:0] bb, input logic signed [17:0] dd,
                       input logic signed [47:0] cc, input logic ci);
    in_valid = v;
    opmode   = op;
    a        = aa;
    b        = bb;
    d        = dd;
    c        = cc;
    carryin  = ci;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 18'sd0, 18'sd0, 18'sd0, 48'sd0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    idle();
    #2;
    chk("rst_p", P, 48'd0);
    chk("rst_vld", {47'd0, out_valid}, 48'd0);
    chk("rst_ovf", {47'd0, ovf}, 48'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // op0: 3*5+100+1
    drive(1, 3'd0, 3, 5, 0, 100, 1); tick();
    idle(); tick();
    chk("op0_early_vld", {47'd0, out_valid}, 48'd0);
    tick();
    chk("op0_p", P, 48'd116);
    chk("op0_vld", {47'd0, out_valid}, 48'd1);
    tick();
    chk("bubble_vld", {47'd0, out_valid}, 48'd0);
    chk("bubble_p", P, 48'd116);

    // op1 / op2 back to back
    drive(1, 3'd1, 3, 5, 2, 100, 1); tick();
    drive(1, 3'd2, 3, 5, 2, 100, 0); tick();
    idle(); tick();
    chk("op1_p", P, 48'd126);
    tick();
    chk("op2_p", P, 48'hFFFF_FFFF_FFFB);
    tick();

    // clear then four chained accumulates
    drive(1, 3'd7, 0, 0, 0, 0, 0); tick();
    drive(1, 3'd3, 2, 3, 0, 0, 0); tick();
    drive(1, 3'd3, 2, 3, 0, 0, 0); tick();
    chk("clr_p", P, 48'd0);
    drive(1, 3'd3, 2, 3, 0, 0, 0); tick();
    chk("acc1", P, 48'd6);
    drive(1, 3'd3, 2, 3, 0, 0, 0); tick();
    chk("acc2", P, 48'd12);
    idle(); tick();
    chk("acc3", P, 48'd18);
    tick();
    chk("acc4", P, 48'd24);

    // op4 subtract, op6 concatenation (positive and zero-extended negative a)
    drive(1, 3'd4, 2, 3, 0, 0, 1); tick();
    drive(1, 3'd6, 1, 2, 0, 10, 0); tick();
    drive(1, 3'd6, -1, 0, 0, 0, 0); tick();
    chk("op4_p", P, 48'd17);
    idle(); tick();
    chk("op6_p", P, 48'd262156);
    tick();
    chk("op6_zext", P, 48'h0000_000F_FFFC_0000);
    chk("no_ovf", {47'd0, ovf}, 48'd0);

    // overflow, stickiness, clear with a younger op right behind
    drive(1, 3'd5, 0, 0, 0, 48'h7FFF_FFFF_FFFF, 1); tick();
    drive(1, 3'd0, 1, 1, 0, 0, 0); tick();
    idle(); tick();
    chk("ovf_p", P, 48'h8000_0000_0000);
    chk("ovf_set", {47'd0, ovf}, 48'd1);
    tick();
    chk("ovf_p2", P, 48'd1);
    chk("ovf_sticky", {47'd0, ovf}, 48'd1);
    drive(1, 3'd7, 0, 0, 0, 0, 0); tick();
    drive(1, 3'd5, 0, 0, 0, 5, 0); tick();
    idle(); tick();
    chk("clr2_p", P, 48'd0);
    chk("clr2_ovf", {47'd0, ovf}, 48'd0);
    chk("clr2_vld", {47'd0, out_valid}, 48'd1);
    tick();
    chk("young_p", P, 48'd5);
    tick();

    // two-cycle clock-enable stall mid-stream
    drive(1, 3'd0, 1, 2, 0, 0, 0); tick();
    drive(1, 3'd0, 2, 2, 0, 0, 0); tick();
    ce = 1'b0;
    drive(1, 3'd0, 7, 7, 0, 9, 1); tick();
    chk("stall1_p", P, 48'd5);
    chk("stall1_vld", {47'd0, out_valid}, 48'd0);
    tick();
    chk("stall2_p", P, 48'd5);
    chk("stall2_vld", {47'd0, out_valid}, 48'd0);
    ce = 1'b1;
    idle(); tick();
    chk("stall_r1_p", P, 48'd2);
    chk("stall_r1_vld", {47'd0, out_valid}, 48'd1);
    tick();
    chk("stall_r2_p", P, 48'd4);
    tick();
    chk("stall_end_vld", {47'd0, out_valid}, 48'd0);

    // asynchronous reset with work in flight
    drive(1, 3'd5, 0, 0, 0, 48'h7FFF_FFFF_FFFF, 1); tick();
    idle(); tick(); tick();
    chk("pre_rst_ovf", {47'd0, ovf}, 48'd1);
    drive(1, 3'd0, 3, 5, 0, 100, 1); tick();
    drive(1, 3'd0, 1, 1, 0, 0, 0); tick();
    drive(1, 3'd0, 2, 2, 0, 0, 0); tick();
    chk("pre_rst_p", P, 48'd116);
    drive(1, 3'd0, 4, 4, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_p", P, 48'd0);
    chk("arst_vld", {47'd0, out_valid}, 48'd0);
    chk("arst_ovf", {47'd0, ovf}, 48'd0);
    tick();
    chk("arst_hold_p", P, 48'd0);
    idle();
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld1", {47'd0, out_valid}, 48'd0);
    tick();
    chk("post_rst_vld2", {47'd0, out_valid}, 48'd0);
    tick();
    chk("post_rst_vld3", {47'd0, out_valid}, 48'd0);
    drive(1, 3'd0, 3, 5, 0, 100, 1); tick();
    idle(); tick();
    chk("post_rst_early", {47'd0, out_valid}, 48'd0);
    tick();
    chk("post_rst_p", P, 48'd116);
    chk("post_rst_vld", {47'd0, out_valid}, 48'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 SHALL have parameter IN_DATA_W_1, default 18, meaning the signed width of a, b and d.
REQ-002 SHALL have parameter IN_DATA_W_2, default 48, meaning the signed width of c.
REQ-003 SHALL have parameter OUT_DATA_W, default 48, meaning the signed width of P; OUT_DATA_W >= 2*IN_DATA_W_1+1 and >= IN_DATA_W_2, checked at elaboration.
REQ-004 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ce  in  1  clock enable for the whole pipeline.
- in_valid  in  1  marks the current input set as an operation.
- opmode  in  3  operation select (REQ-010).
- a, b, d  in  IN_DATA_W_1 each  signed operands.
- c  in  IN_DATA_W_2  signed addend.
- carryin  in  1  carry, added as +1.
- P  out  OUT_DATA_W  signed result / accumulator.
- out_valid  out  1  P updated this cycle.
- ovf  out  1  sticky signed overflow.

Function
REQ-005 SHALL be a 3-stage pipeline: S1 registers all inputs; S2 registers pre-add and multiply; S3 registers post-add into P.
REQ-006 SHALL give latency 3 edges: in_valid=1 sampled at edge N with ce=1 -> P and out_valid update at edge N+2 (ce=1 on each edge).
REQ-007 SHALL accept one operation per cycle; no back-pressure output.
REQ-008 SHALL freeze every pipeline register, P, out_valid and ovf on any edge with ce=0.
REQ-009 SHALL propagate in_valid=0 as a bubble: out_valid=0 and P holds its value at the matching S3 edge.
REQ-010 SHALL implement opmode, all signed, each result sign-extended/truncated to OUT_DATA_W:
- 0: a*b + c + carryin.
- 1: (d+a)*b + c + carryin; pre-add width IN_DATA_W_1+1.
- 2: (d-a)*b + carryin.
- 3: P + a*b + carryin (accumulate).
- 4: P - a*b - carryin.
- 5: c + carryin.
- 6: {a,b} zero-extended + c.
- 7: P := 0 and ovf := 0.
REQ-011 SHALL read P for opmodes 3/4 at S3 from the current P register, so back-to-back accumulates chain with no hazard.
REQ-012 SHALL set ovf at the S3 edge when the OUT_DATA_W-bit signed post-add overflows (operand signs equal, result sign differs); P keeps the wrapped two's-complement value.
REQ-013 SHALL hold ovf until reset or an opmode-7 operation reaches S3.
REQ-014 SHALL, on opmode 7 reaching S3 in the same cycle as a new in_valid at S1, apply the clear; the younger operation is unaffected and is processed normally.
REQ-015 SHALL treat in_valid=0 operands as don't-care; they never change P or ovf.

Reset
REQ-016 SHALL, when rst_n=0, immediately clear all stage registers, P=0, out_valid=0, ovf=0, regardless of clk or ce.
REQ-017 SHALL discard all in-flight operations on reset; the first out_valid after release comes exactly 3 edges after the first accepted in_valid.
REQ-018 SHALL release reset synchronously to clk (external synchroniser); no output glitches on deassertion.

Structure
REQ-019 SHALL place opmode encodings (OP_MUL_ADD .. OP_CLR) and the opmode width in shared package dsp_mac_pkg.
REQ-020 SHALL isolate the pre-adder and multiplier (S2) in sub-module dsp_mac_mult, parametrised by IN_DATA_W_1.
REQ-021 SHALL keep the post-adder, accumulator feedback and ovf logic in dsp_mac_pipe.

Verification
REQ-022 SHALL cover: op0, a=3, b=5, c=100, carryin=1 -> P=116, out_valid=1 at edge N+2.
REQ-023 SHALL cover: op1, d=2, a=3, b=5, c=100, carryin=1 -> P=126; op2, d=2, a=3, b=5, carryin=0 -> P=-5.
REQ-024 SHALL cover: op7, then four back-to-back op3 with a=2, b=3, carryin=0 -> P=6, 12, 18, 24 on consecutive cycles.
REQ-025 SHALL cover: op5, c=48'h7FFF_FFFF_FFFF, carryin=1 -> P=48'h8000_0000_0000, ovf=1; ovf stays 1 until a following op7 -> P=0, ovf=0.
REQ-026 SHALL cover: ce=0 for 2 cycles mid-stream -> outputs frozen, results delayed by exactly 2 cycles, values unchanged.
REQ-027 SHALL cover: rst_n pulsed low mid-cycle with 3 operations in flight -> P=0, out_valid=0, ovf=0 immediately; no stale out_valid after release.
